reorder_buffer: RTL and testbench

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 51 +++++
 rtl/reorder_buffer_if.sv | 36 +++
 rtl/reorder_buffer.sv | 141 ++++++++++++++
 tb/tb_reorder_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared rv32i pipeline types used by the reorder buffer.
// Adds the wrap-bit pointer type rob_ptr_t.
package rv32i_types;

   localparam int ROB_D = 8;
   localparam int CDB   = 2;
   localparam int RID_W = $clog2(ROB_D);

   typedef logic [RID_W:0] rob_ptr_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd_addr;
      logic        predict_branch;
      logic        is_branch;
      logic        is_jump;
      logic        is_jumpr;
   } inst_t;

   typedef struct packed {
      logic [RID_W-1:0] rob_id;
      logic [31:0]      fu_value;
      logic             branch_enable;
      logic             mispredict;
   } rob_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] order;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
   } rvfi_t;

   typedef struct packed {
      inst_t inst;
      rob_t  rob;
      rvfi_t rvfi;
   } super_dispatch_t;

   typedef struct packed {
      logic            ready_for_writeback;
      logic [31:0]     register_value;
      logic            branch_result;
      super_dispatch_t inst_info;
   } fu_output_t;

   typedef fu_output_t cdb_t;

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch / writeback / commit bundle between pipeline and ROB.
// master = pipeline side, slave = reorder buffer.
interface reorder_buffer_if
   import rv32i_types::*;
#(
   parameter int ROB_DEPTH = ROB_D,
   parameter int CDB_PORTS = CDB
);

   logic                         dispatch_valid;
   super_dispatch_t              dispatch_data;
   logic                         dispatch_ready;
   logic [$clog2(ROB_DEPTH)-1:0] dispatch_rob_id;
   cdb_t                         cdb [CDB_PORTS];
   logic                         commit_valid;
   super_dispatch_t              commit_data;
   logic                         flush;
   logic [31:0]                  flush_pc;
   logic                         full;
   logic                         empty;

   modport master (
      output dispatch_valid, dispatch_data, cdb,
      input  dispatch_ready, dispatch_rob_id,
      input  commit_valid, commit_data,
      input  flush, flush_pc, full, empty
   );

   modport slave (
      input  dispatch_valid, dispatch_data, cdb,
      output dispatch_ready, dispatch_rob_id,
      output commit_valid, commit_data,
      output flush, flush_pc, full, empty
   );

endinterface

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with multi-port CDB writeback.
// Define ROB_RVFI_EN to emit RVFI valid/order on commit_data.
module reorder_buffer
   import rv32i_types::*;
#(
   parameter int ROB_DEPTH = ROB_D,
   parameter int CDB_PORTS = CDB
) (
   input logic             clk,
   input logic             rst_n,
   reorder_buffer_if.slave bus
);

   localparam int IW = $clog2(ROB_DEPTH);

   typedef logic [IW:0] ptr_t;

   ptr_t                 head;
   ptr_t                 tail;
   logic [ROB_DEPTH-1:0] valid;
   logic [ROB_DEPTH-1:0] done;
   super_dispatch_t      ent [ROB_DEPTH];

   logic [IW-1:0]        head_idx;
   logic [IW-1:0]        tail_idx;
   logic                 do_dispatch;
   logic [IW-1:0]        cdb_id [CDB_PORTS];
   logic [CDB_PORTS-1:0] cdb_hit;
   logic                 unused_cdb;

   assign head_idx = head[IW-1:0];
   assign tail_idx = tail[IW-1:0];

   assign bus.empty = (head == tail);
   assign bus.full  = (head_idx == tail_idx)
                   && (head[IW] != tail[IW]);

   assign bus.commit_valid = valid[head_idx] && done[head_idx];
   assign bus.flush = bus.commit_valid
                   && ent[head_idx].rob.mispredict;
   assign bus.flush_pc = bus.flush
                       ? ent[head_idx].rvfi.pc_wdata : '0;

   // Full blocks dispatch even when the head retires this cycle.
   assign bus.dispatch_ready  = !bus.full && !bus.flush;
   assign bus.dispatch_rob_id = tail_idx;
   assign do_dispatch = bus.dispatch_valid && bus.dispatch_ready;

   always_comb begin
      unused_cdb = 1'b0;
      for (int p = 0; p < CDB_PORTS; p++) begin
         cdb_id[p]  = IW'(bus.cdb[p].inst_info.rob.rob_id);
         cdb_hit[p] = bus.cdb[p].ready_for_writeback
                   && valid[cdb_id[p]]
                   && !done[cdb_id[p]];
         unused_cdb = unused_cdb ^ (^bus.cdb[p].inst_info);
      end
   end

`ifdef ROB_RVFI_EN
   logic [63:0] order_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         order_cnt <= '0;
      else if (bus.commit_valid)
         order_cnt <= order_cnt + 64'd1;
   end
`endif

   always_comb begin
      bus.commit_data = '0;
      if (bus.commit_valid) begin
         bus.commit_data = ent[head_idx];
`ifdef ROB_RVFI_EN
         bus.commit_data.rvfi.valid = 1'b1;
         bus.commit_data.rvfi.order = order_cnt;
`else
         bus.commit_data.rvfi = '0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         valid <= '0;
         done  <= '0;
      end else if (bus.flush) begin
         valid <= '0;
         done  <= '0;
         head  <= head + 1'b1;
         tail  <= head + 1'b1;
      end else begin
         if (bus.commit_valid) begin
            valid[head_idx] <= 1'b0;
            done[head_idx]  <= 1'b0;
            head <= head + 1'b1;
         end
         if (do_dispatch) begin
            valid[tail_idx] <= 1'b1;
            done[tail_idx]  <= 1'b0;
            tail <= tail + 1'b1;
         end
         for (int p = 0; p < CDB_PORTS; p++)
            if (cdb_hit[p])
               done[cdb_id[p]] <= 1'b1;
      end
   end

   // Ports walk high to low so port 0 lands last on a shared id.
   always_ff @(posedge clk) begin
      if (!bus.flush) begin
         if (do_dispatch) begin
            ent[tail_idx] <= bus.dispatch_data;
            ent[tail_idx].rob.rob_id <= RID_W'(tail_idx);
            ent[tail_idx].rob.mispredict <= 1'b0;
         end
         for (int p = CDB_PORTS - 1; p >= 0; p--) begin
            if (cdb_hit[p]) begin
               ent[cdb_id[p]].rob.fu_value <=
                  bus.cdb[p].register_value;
               ent[cdb_id[p]].rvfi.rd_wdata <=
                  bus.cdb[p].register_value;
               ent[cdb_id[p]].rob.branch_enable <=
                  bus.cdb[p].branch_result;
               ent[cdb_id[p]].rob.mispredict <=
                  (ent[cdb_id[p]].inst.is_branch
                   || ent[cdb_id[p]].inst.is_jump
                   || ent[cdb_id[p]].inst.is_jumpr)
                  && (bus.cdb[p].branch_result
                      != ent[cdb_id[p]].inst.predict_branch);
               ent[cdb_id[p]].rvfi.pc_wdata <=
                  bus.cdb[p].inst_info.rvfi.pc_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: table-driven in-order flow
// plus hand sequences for full, wrap, flush, CDB ports, reset.
module tb_reorder_buffer;
   import rv32i_types::*;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   logic [63:0] n_commit;

   reorder_buffer_if bus ();

   reorder_buffer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        dv;
      logic [31:0] dpc;
      logic        cv;
      logic [2:0]  cid;
      logic [31:0] cval;
      logic        e_commit;
      logic [2:0]  e_rid;
      logic [2:0]  e_cid;
      logic [31:0] e_fu;
      logic [31:0] e_pc;
      logic        e_empty;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h",
                    nm, act, exp);
   endtask

   task automatic set_cdb(input int p, input logic v,
                          input int id,
                          input logic [31:0] val,
                          input logic br,
                          input logic [31:0] pcw);
      cdb_t c;
      logic [2:0] idb;
      idb = id[2:0];
      c = '0;
      c.ready_for_writeback = v;
      c.register_value = val;
      c.branch_result = br;
      c.inst_info.rob.rob_id = idb;
      c.inst_info.rvfi.pc_wdata = pcw;
      if (p == 0) bus.cdb[0] = c;
      else bus.cdb[1] = c;
   endtask

   task automatic set_disp(input logic v,
                           input logic [31:0] pc,
                           input logic br,
                           input logic pred);
      super_dispatch_t d;
      d = '0;
      d.inst.pc = pc;
      d.inst.is_branch = br;
      d.inst.predict_branch = pred;
      d.rvfi.pc_rdata = pc;
      bus.dispatch_data = d;
      bus.dispatch_valid = v;
   endtask

   task automatic idle();
      set_disp(1'b0, 32'h0, 1'b0, 1'b0);
      set_cdb(0, 1'b0, 0, 32'h0, 1'b0, 32'h0);
      set_cdb(1, 1'b0, 0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_commit = '0;
   endtask

   task automatic chk_commit(input string nm,
                             input int id,
                             input logic [31:0] fu);
      chk({nm, "_cv"}, 64'(bus.commit_valid), 64'd1);
      chk({nm, "_id"}, 64'(bus.commit_data.rob.rob_id),
          64'(id));
      chk({nm, "_fu"}, 64'(bus.commit_data.rob.fu_value),
          64'(fu));
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      n_commit = '0;
      rst_n = 1'b0;
      idle();
      #2;
      chk("rst_ready", 64'(bus.dispatch_ready), 64'd1);
      chk("rst_rid", 64'(bus.dispatch_rob_id), 64'd0);
      chk("rst_cv", 64'(bus.commit_valid), 64'd0);
      chk("rst_cdata", 64'(bus.commit_data == '0), 64'd1);
      chk("rst_flush", 64'(bus.flush), 64'd0);
      chk("rst_fpc", 64'(bus.flush_pc), 64'd0);
      chk("rst_full", 64'(bus.full), 64'd0);
      chk("rst_empty", 64'(bus.empty), 64'd1);

      // dispatch 0,1,2; CDB completes 1, 0, 2; commits in order
      tbl[0] = '{1, 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      tbl[1] = '{1, 32'h104, 0, 0, 0, 0, 1, 0, 0, 0, 0};
      tbl[2] = '{1, 32'h108, 0, 0, 0, 0, 2, 0, 0, 0, 0};
      tbl[3] = '{0, 0, 1, 1, 32'h11, 0, 3, 0, 0, 0, 0};
      tbl[4] = '{0, 0, 1, 0, 32'hA0, 0, 3, 0, 0, 0, 0};
      tbl[5] = '{0, 0, 1, 2, 32'h22, 1, 3, 0,
                 32'hA0, 32'h100, 0};
      tbl[6] = '{0, 0, 0, 0, 0, 1, 3, 1,
                 32'h11, 32'h104, 0};
      tbl[7] = '{0, 0, 0, 0, 0, 1, 3, 2,
                 32'h22, 32'h108, 0};
      tbl[8] = '{0, 0, 0, 0, 0, 0, 3, 0, 0, 0, 1};

      do_reset();
      for (int i = 0; i < 9; i++) begin
         idle();
         set_disp(tbl[i].dv, tbl[i].dpc, 1'b0, 1'b0);
         set_cdb(0, tbl[i].cv, int'(tbl[i].cid),
                 tbl[i].cval, 1'b0, 32'h0);
         #1;
         chk("tbl_rid", 64'(bus.dispatch_rob_id),
             64'(tbl[i].e_rid));
         chk("tbl_cv", 64'(bus.commit_valid),
             64'(tbl[i].e_commit));
         chk("tbl_empty", 64'(bus.empty), 64'(tbl[i].e_empty));
         if (tbl[i].e_commit) begin
            chk("tbl_cid", 64'(bus.commit_data.rob.rob_id),
                64'(tbl[i].e_cid));
            chk("tbl_fu", 64'(bus.commit_data.rob.fu_value),
                64'(tbl[i].e_fu));
            chk("tbl_pc", 64'(bus.commit_data.inst.pc),
                64'(tbl[i].e_pc));
`ifdef ROB_RVFI_EN
            chk("tbl_order", bus.commit_data.rvfi.order,
                n_commit);
            chk("tbl_rvalid", 64'(bus.commit_data.rvfi.valid),
                64'd1);
            chk("tbl_rdw", 64'(bus.commit_data.rvfi.rd_wdata),
                64'(tbl[i].e_fu));
`else
            chk("tbl_rvfi0", 64'(bus.commit_data.rvfi == '0),
                64'd1);
`endif
            n_commit++;
         end
         tick();
      end

      // fill all 8 entries, then free one via the head
      do_reset();
      for (int i = 0; i < 8; i++) begin
         set_disp(1'b1, 32'h400 + 32'(i * 4), 1'b0, 1'b0);
         #1;
         chk("full_rid", 64'(bus.dispatch_rob_id), 64'(i));
         chk("full_rdy", 64'(bus.dispatch_ready), 64'd1);
         tick();
      end
      chk("full_full", 64'(bus.full), 64'd1);
      chk("full_rdy0", 64'(bus.dispatch_ready), 64'd0);
      set_disp(1'b1, 32'hBAD, 1'b0, 1'b0);
      set_cdb(0, 1'b1, 0, 32'h70, 1'b0, 32'h0);
      #1;
      tick();
      chk_commit("full_c0", 0, 32'h70);
      chk("full_pc", 64'(bus.commit_data.inst.pc), 64'h400);
      chk("full_nobyp", 64'(bus.dispatch_ready), 64'd0);
      tick();
      chk("full_after", 64'(bus.full), 64'd0);
      chk("full_rdy1", 64'(bus.dispatch_ready), 64'd1);
      chk("full_rid0", 64'(bus.dispatch_rob_id), 64'd0);
      chk("full_cv0", 64'(bus.commit_valid), 64'd0);

      // steady flow across the wrap point
      do_reset();
      for (int i = 0; i < 22; i++) begin
         idle();
         if (i < 20)
            set_disp(1'b1, 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
         if (i >= 1 && i <= 20)
            set_cdb(0, 1'b1, (i - 1) % 8,
                    32'h5000 + 32'(i - 1), 1'b0, 32'h0);
         #1;
         if (i < 20)
            chk("wrap_rid", 64'(bus.dispatch_rob_id),
                64'(i % 8));
         chk("wrap_cv", 64'(bus.commit_valid), 64'(i >= 2));
         if (i >= 2) begin
            chk("wrap_fu", 64'(bus.commit_data.rob.fu_value),
                64'(32'h5000 + 32'(i - 2)));
            chk("wrap_pc", 64'(bus.commit_data.inst.pc),
                64'(32'h1000 + 32'((i - 2) * 4)));
         end
         tick();
      end
      chk("wrap_empty", 64'(bus.empty), 64'd1);

      // mispredicted branch at id 3 squashes ids 4..6
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_disp(1'b1, 32'h200 + 32'(i * 4), i == 3, 1'b0);
         tick();
      end
      set_cdb(0, 1'b1, 0, 32'h10, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 1, 32'h11, 1'b0, 32'h0);
      #1;
      chk("br_cv0", 64'(bus.commit_valid), 64'd0);
      tick();
      set_cdb(0, 1'b1, 2, 32'h12, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 3, 32'h33, 1'b1, 32'h60000040);
      #1;
      chk_commit("br_c0", 0, 32'h10);
      tick();
      set_cdb(0, 1'b1, 4, 32'h44, 1'b0, 32'h0);
      #1;
      chk_commit("br_c1", 1, 32'h11);
      chk("br_nofl1", 64'(bus.flush), 64'd0);
      tick();
      chk_commit("br_c2", 2, 32'h12);
      chk("br_nofl2", 64'(bus.flush), 64'd0);
      tick();
      set_disp(1'b1, 32'h999, 1'b0, 1'b0);
      set_cdb(0, 1'b1, 5, 32'h55, 1'b0, 32'h0);
      #1;
      chk_commit("br_c3", 3, 32'h33);
      chk("br_flush", 64'(bus.flush), 64'd1);
      chk("br_fpc", 64'(bus.flush_pc), 64'h60000040);
      chk("br_rdy", 64'(bus.dispatch_ready), 64'd0);
      chk("br_misp", 64'(bus.commit_data.rob.mispredict), 64'd1);
      chk("br_ben", 64'(bus.commit_data.rob.branch_enable),
          64'd1);
      tick();
      chk("br_empty", 64'(bus.empty), 64'd1);
      chk("br_flush0", 64'(bus.flush), 64'd0);
      for (int i = 0; i < 3; i++) begin
         chk("br_nocommit", 64'(bus.commit_valid), 64'd0);
         tick();
      end
      set_disp(1'b1, 32'h300, 1'b0, 1'b0);
      #1;
      chk("br_rid4", 64'(bus.dispatch_rob_id), 64'd4);
      tick();
      chk("br_new_cv0", 64'(bus.commit_valid), 64'd0);
      set_cdb(0, 1'b1, 4, 32'h4A, 1'b0, 32'h0);
      tick();
      chk_commit("br_new", 4, 32'h4A);
      chk("br_new_pc", 64'(bus.commit_data.inst.pc), 64'h300);

      // two CDB ports per cycle, shared id and stale writes
      do_reset();
      for (int i = 0; i < 6; i++) begin
         set_disp(1'b1, 32'h700 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      set_cdb(0, 1'b1, 2, 32'h222, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 5, 32'h555, 1'b0, 32'h0);
      tick();
      set_cdb(0, 1'b1, 0, 32'hAAA, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 0, 32'hBBB, 1'b0, 32'h0);
      tick();
      set_cdb(0, 1'b1, 1, 32'h111, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 3, 32'h333, 1'b0, 32'h0);
      #1;
      chk_commit("cdb_c0", 0, 32'hAAA);
      tick();
      set_cdb(0, 1'b1, 4, 32'h444, 1'b0, 32'h0);
      set_cdb(1, 1'b1, 2, 32'hDEAD, 1'b0, 32'h0);
      #1;
      chk_commit("cdb_c1", 1, 32'h111);
      tick();
      chk_commit("cdb_c2", 2, 32'h222);
      tick();
      chk_commit("cdb_c3", 3, 32'h333);
      tick();
      chk_commit("cdb_c4", 4, 32'h444);
      tick();
      chk_commit("cdb_c5", 5, 32'h555);
      tick();
      chk("cdb_empty", 64'(bus.empty), 64'd1);

      // asynchronous reset with entries in flight
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_disp(1'b1, 32'h800 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      set_cdb(0, 1'b1, 0, 32'h88, 1'b0, 32'h0);
      tick();
      chk("ar_cv1", 64'(bus.commit_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_empty", 64'(bus.empty), 64'd1);
      chk("ar_cv0", 64'(bus.commit_valid), 64'd0);
      chk("ar_rdy", 64'(bus.dispatch_ready), 64'd1);
      chk("ar_rid", 64'(bus.dispatch_rob_id), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_disp(1'b1, 32'h900, 1'b0, 1'b0);
      #1;
      chk("ar_rid0", 64'(bus.dispatch_rob_id), 64'd0);
      tick();
      set_cdb(0, 1'b1, 0, 32'h99, 1'b0, 32'h0);
      tick();
      chk_commit("ar_c0", 0, 32'h99);
      chk("ar_pc", 64'(bus.commit_data.inst.pc), 64'h900);
      tick();
      chk("ar_end_empty", 64'(bus.empty), 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
